// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the SoC UART transmitter and receiver.
//   uart_state_t  - receiver FSM state encoding (2-bit)
//   DATA_BITS     - data bits per frame
//   STOP_BITS     - stop bits per frame
//   uart_timing() - bit period P and half period H derived from clock/baud,
//                   so both directions agree on the bit period
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned STOP_BITS = 1;

   typedef struct packed {
      int unsigned period;
      int unsigned half;
   } uart_timing_t;

   function automatic uart_timing_t uart_timing(input int unsigned clk_hz,
                                                input int unsigned baud);
      uart_timing_t t;
      t.period = clk_hz / baud;
      t.half   = t.period / 2;
      return t;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous serial line.
//   i_clk - system clock
//   i_rst - asynchronous active-high reset; both flops reset to 1 (line idle)
//   i_d   - asynchronous input
//   o_q   - synchronised output, two cycles behind i_d
module uart_rx_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic meta;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         meta <= 1'b1;
         o_q  <= 1'b1;
      end else begin
         meta <= i_d;
         o_q  <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, mid-bit sampling, valid/ready output buffer.
//   i_clk       - system clock (rising edge)
//   i_rst       - asynchronous active-high reset
//   i_uart_rx   - serial line, asynchronous, idles high
//   o_data      - received byte, stable while o_valid=1
//   o_valid     - o_data holds an unconsumed byte
//   i_ready     - consumer accepts; transfer on o_valid & i_ready
//   o_frame_err - one-cycle pulse: stop bit sampled low
//   o_overrun   - one-cycle pulse: byte completed while buffer still full
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned clk_freq_hz = 100000000,
   parameter int unsigned baud_rate   = 115200
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_uart_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_frame_err,
   output logic                 o_overrun
);

   localparam uart_timing_t TIMING = uart_timing(clk_freq_hz, baud_rate);
   localparam int unsigned  P      = TIMING.period;
   localparam int unsigned  H      = TIMING.half;
   localparam int unsigned  CW     = $clog2(P) + 1;

   if (P < 4 || STOP_BITS != 1) begin : g_param_check
      $fatal(1, "uart_rx: bit period below 4 clocks or unsupported stop bits");
   end

   logic                 rx_s;
   uart_state_t          state, state_nxt;
   logic [CW-1:0]        cnt;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 armed;
   logic [1:0]           settle;
   logic                 tick;
   logic                 start_det, start_ok, data_smp, stop_good, stop_bad, arm_set;

   uart_rx_sync u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_uart_rx),
      .o_q   (rx_s)
   );

   assign tick = (cnt == '0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (armed && !rx_s) state_nxt = START;
         START: if (tick) state_nxt = rx_s ? IDLE : DATA;
         DATA:  if (tick && bit_idx == 3'(DATA_BITS - 1)) state_nxt = STOP;
         STOP:  if (tick) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The synchroniser flops reset to 1, so rx_s reads high for two cycles
   // after reset regardless of the line; arming waits for settle[1] so a
   // line held low through reset release is not mistaken for idle.
   always_comb begin
      start_det = (state == IDLE)  && armed && !rx_s;
      start_ok  = (state == START) && tick  && !rx_s;
      data_smp  = (state == DATA)  && tick;
      stop_good = (state == STOP)  && tick  && rx_s;
      stop_bad  = (state == STOP)  && tick  && !rx_s;
      arm_set   = (state == IDLE)  && rx_s  && settle[1];
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         armed   <= 1'b0;
         settle  <= '0;
      end else begin
         settle <= {settle[0], 1'b1};

         if (stop_bad)     armed <= 1'b0;
         else if (arm_set) armed <= 1'b1;

         if (start_det)                 cnt <= CW'(H - 1);
         else if (start_ok || data_smp) cnt <= CW'(P - 1);
         else if (state != IDLE && !tick) cnt <= cnt - CW'(1);

         if (start_ok)      bit_idx <= '0;
         else if (data_smp) bit_idx <= bit_idx + 3'd1;

         if (data_smp) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      end
   end

   // A completed byte may load in the same cycle the old one is accepted;
   // the load takes priority over the valid drop.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_data      <= '0;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         o_frame_err <= stop_bad;
         o_overrun   <= stop_good && o_valid && !i_ready;
         if (stop_good && (!o_valid || i_ready)) begin
            o_data  <= shreg;
            o_valid <= 1'b1;
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 1 MHz / 100 kbaud (P=10, H=5).
module tb_uart_rx;
   import uart_pkg::*;

   localparam int BIT_P = 10;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_uart_rx = 1'b1;
   logic       i_ready = 1'b0;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_frame_err;
   logic       o_overrun;

   int total = 0;
   int bad   = 0;

   int cyc = 0;
   int n_ferr, n_ovr, n_vhi, n_vlo;
   int t_rise, t_fall;
   logic prev_v = 1'b0;

   uart_rx #(.clk_freq_hz(1000000), .baud_rate(100000)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_uart_rx   (i_uart_rx),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_frame_err (o_frame_err),
      .o_overrun   (o_overrun)
   );

   always #5 i_clk = ~i_clk;

   // Sampled 2 ns after each rising edge.
   always @(posedge i_clk) begin
      cyc++;
      #2;
      if (o_frame_err) n_ferr++;
      if (o_overrun)   n_ovr++;
      if (o_valid) n_vhi++;
      else         n_vlo++;
      if (o_valid && !prev_v && t_rise < 0) t_rise = cyc;
      prev_v = o_valid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      n_ferr = 0; n_ovr = 0; n_vhi = 0; n_vlo = 0; t_rise = -1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   task automatic drive_bit(input logic b);
      i_uart_rx = b;
      repeat (BIT_P) @(negedge i_clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop);
   endtask

   initial begin
      clr();
      idle(3);
      check("rst_data",  32'(o_data), 32'h00);
      check("rst_valid", 32'(o_valid), 32'h0);
      check("rst_ferr",  32'(o_frame_err), 32'h0);
      check("rst_ovr",   32'(o_overrun), 32'h0);
      check("rst_state", 32'(dut.state), 32'(IDLE));
      i_rst = 1'b0;
      idle(20);

      // 1: single byte, consumer ready
      i_ready = 1'b1;
      clr();
      t_fall = cyc;
      send_frame(8'hA5, 1'b1);
      idle(20);
      check("t1_latency", 32'(t_rise - t_fall), 32'd98);
      check("t1_data",    32'(o_data), 32'hA5);
      check("t1_vpulse",  32'(n_vhi), 32'd1);
      check("t1_flags",   32'(n_ferr + n_ovr), 32'd0);

      // 2: back-to-back with consumer stalled -> overrun, old byte kept
      i_ready = 1'b0;
      clr();
      send_frame(8'h3C, 1'b1);
      send_frame(8'h81, 1'b1);
      idle(20);
      check("t2_valid",   32'(o_valid), 32'h1);
      check("t2_data",    32'(o_data), 32'h3C);
      check("t2_overrun", 32'(n_ovr), 32'd1);
      check("t2_ferr",    32'(n_ferr), 32'd0);
      i_ready = 1'b1;
      idle(1);
      check("t2_accept",  32'(o_valid), 32'h0);

      // 3: bad stop bit, line held low as a break, then recovery
      clr();
      send_frame(8'h55, 1'b0);
      i_uart_rx = 1'b0;
      idle(50 * BIT_P);
      check("t3_ferr",    32'(n_ferr), 32'd1);
      check("t3_novalid", 32'(n_vhi), 32'd0);
      i_uart_rx = 1'b1;
      idle(30);
      clr();
      send_frame(8'h12, 1'b1);
      idle(20);
      check("t3_data",    32'(o_data), 32'h12);
      check("t3_vpulse",  32'(n_vhi), 32'd1);
      check("t3_flags",   32'(n_ferr + n_ovr), 32'd0);

      // 4: 3-cycle glitch is a false start
      clr();
      i_uart_rx = 1'b0;
      idle(3);
      i_uart_rx = 1'b1;
      check("t4_start",   32'(dut.state), 32'(START));
      idle(5);
      check("t4_idle",    32'(dut.state), 32'(IDLE));
      idle(120);
      check("t4_quiet",   32'(n_vhi + n_ferr + n_ovr), 32'd0);

      // 5: reset mid-frame after bit 3 of 0xFF, line low at release
      clr();
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      i_rst = 1'b1;
      i_uart_rx = 1'b0;
      idle(3);
      check("t5_rst_state", 32'(dut.state), 32'(IDLE));
      check("t5_rst_data",  32'(o_data), 32'h00);
      i_rst = 1'b0;
      clr();
      idle(150);
      check("t5_quiet",   32'(n_vhi + n_ferr + n_ovr), 32'd0);
      i_uart_rx = 1'b1;
      idle(20);
      clr();
      t_fall = cyc;
      send_frame(8'h0F, 1'b1);
      idle(20);
      check("t5_latency", 32'(t_rise - t_fall), 32'd98);
      check("t5_data",    32'(o_data), 32'h0F);
      check("t5_flags",   32'(n_ferr + n_ovr), 32'd0);

      // 6: new byte loads in the same cycle the old one is accepted
      i_ready = 1'b0;
      send_frame(8'h11, 1'b1);
      check("t6_first",   32'(o_data), 32'h11);
      clr();
      fork
         send_frame(8'h22, 1'b1);
         begin
            idle(97);
            check("t6_hold",  32'(o_data), 32'h11);
            i_ready = 1'b1;
            idle(1);
            i_ready = 1'b0;
         end
      join
      idle(10);
      check("t6_valid",   32'(o_valid), 32'h1);
      check("t6_data",    32'(o_data), 32'h22);
      check("t6_nodrop",  32'(n_vlo), 32'd0);
      check("t6_overrun", 32'(n_ovr), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
